// File: rtl/risc_controller_pkg.sv
// Shared constants and types for the accumulator RISC sequencing controller.
// Holds bus widths, the opcode set and the controller state encoding.
package risc_controller_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    // Instructions that read a memory operand and write the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational strobe decode: maps controller state, opcode and zero flag
// to the address-mux select and the load/read/write strobes.
module risc_ctrl_decode
    import risc_controller_pkg::*;
(
    input  state_t  state,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    sel,
    output logic    rd,
    output logic    wr,
    output logic    ld_ir,
    output logic    inc_pc,
    output logic    ld_pc,
    output logic    ld_ac,
    output logic    data_e,
    output logic    halt
);

    logic alu;
    logic sto;
    logic jmp;

    assign alu = is_aluop(opcode);
    assign sto = (opcode == STO);
    assign jmp = (opcode == JMP);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (state)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = (opcode != HLT);
            end
            OP_FETCH: begin
                rd = alu;
            end
            // zero only matters here: SKZ skips the next word by a second increment.
            ALU_OP: begin
                rd     = alu;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = jmp;
                data_e = sto;
            end
            STORE: begin
                rd     = alu;
                ld_ac  = alu;
                ld_pc  = jmp;
                inc_pc = jmp;
                wr     = sto;
                data_e = sto;
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/risc_controller.sv
// Sequencing controller for the 8-opcode accumulator CPU: 8-phase Moore FSM
// plus a sticky HALTED state. Optional memory wait states: RISC_CTRL_MEM_WAIT_EN.
module risc_controller
    import risc_controller_pkg::*;
#(
    parameter int OPCODE_WIDTH = 3,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
`ifdef RISC_CTRL_MEM_WAIT_EN
    input  logic                    mem_ready,
`endif
    output logic                    sel,
    output logic                    rd,
    output logic                    wr,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    ld_ac,
    output logic                    data_e,
    output logic                    halt,
    output logic [STATE_WIDTH-1:0]  phase
);

    state_t  state_q;
    state_t  state_d;
    opcode_t op;

    assign op    = opcode_t'(opcode[2:0]);
    assign phase = STATE_WIDTH'(state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INST_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INST_ADDR:  state_d = INST_FETCH;
            INST_FETCH: state_d = INST_LOAD;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (op == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_d = ALU_OP;
            ALU_OP:     state_d = STORE;
            STORE:      state_d = INST_ADDR;
            HALTED:     state_d = HALTED;
            default:    state_d = INST_ADDR;
        endcase
`ifdef RISC_CTRL_MEM_WAIT_EN
        // Hold only in states that actually have a memory access in flight.
        if (!mem_ready &&
            ((state_q == INST_FETCH) ||
             ((state_q == OP_FETCH) && is_aluop(op)) ||
             ((state_q == STORE) && (op == STO)))) begin
            state_d = state_q;
        end
`endif
    end

    risc_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (op),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .data_e (data_e),
        .halt   (halt)
    );

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: a driver pushes the expected per-cycle
// phase/strobe vector from a reference model; a monitor pops and compares.
module tb_risc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
`ifdef RISC_CTRL_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
    bit         rand_rdy = 1'b0;
    int         stall_left = 0;
    int         stall_at = 5;
`endif

    logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [3:0] phase;
    logic [12:0] act;

    int n_vec = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];
    int m_phase = 0;

    risc_controller dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
`ifdef RISC_CTRL_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .ld_ac     (ld_ac),
        .data_e    (data_e),
        .halt      (halt),
        .phase     (phase)
    );

    assign act = {phase, sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};

    always #5 clk = ~clk;

    // Reference: strobe table per phase, opcode 0=HLT 1=SKZ 2..5=ALU 6=STO 7=JMP.
    function automatic logic [12:0] exp_vec(int p, logic [2:0] op, logic z);
        logic alu, s, r, w, li, ip, lp, la, de, h;
        alu = (op >= 3'd2) && (op <= 3'd5);
        {s, r, w, li, ip, lp, la, de, h} = 9'b0;
        case (p)
            0: s = 1'b1;
            1: begin s = 1'b1; r = 1'b1; end
            2, 3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
            4: ip = (op != 3'd0);
            5: r = alu;
            6: begin
                r  = alu;
                ip = (op == 3'd1) && z;
                lp = (op == 3'd7);
                de = (op == 3'd6);
            end
            7: begin
                r  = alu;
                la = alu;
                lp = (op == 3'd7);
                ip = (op == 3'd7);
                w  = (op == 3'd6);
                de = (op == 3'd6);
            end
            8: h = 1'b1;
            default: ;
        endcase
        return {4'(p), s, r, w, li, ip, lp, la, de, h};
    endfunction

    function automatic int next_phase(int p, logic [2:0] op);
        if (p == 8) return 8;
        if (p == 4 && op == 3'd0) return 8;
        if (p == 7) return 0;
        return p + 1;
    endfunction

    // Drive one cycle (called at posedge+1), record the expectation, advance.
    task automatic step(input logic [2:0] op, input logic z);
        int np;
        opcode = op;
        zero   = z;
        np = next_phase(m_phase, op);
`ifdef RISC_CTRL_MEM_WAIT_EN
        begin
            logic rdy;
            logic waits;
            waits = (m_phase == 1) ||
                    (m_phase == 5 && op >= 3'd2 && op <= 3'd5) ||
                    (m_phase == 7 && op == 3'd6);
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            else if (m_phase == stall_at && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else rdy = 1'b1;
            mem_ready = rdy;
            if (waits && !rdy) np = m_phase;
        end
`endif
        exp_q.push_back(exp_vec(m_phase, op, z));
        @(posedge clk);
        #1;
        m_phase = np;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            exp_q.push_back(exp_vec(0, opcode, zero));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        m_phase = 0;
    endtask

    // z6: 0/1 forces zero in ALU_OP, 2 randomizes; zero is random elsewhere.
    task automatic run_instr(input logic [2:0] op, input int z6);
        int cyc;
        logic [2:0] o;
        logic z;
        cyc = 0;
        do begin
            o = (m_phase < 2) ? 3'($urandom_range(0, 7)) : op;
            z = (m_phase == 6 && z6 < 2) ? z6[0] : 1'($urandom_range(0, 1));
            step(o, z);
            cyc++;
        end while (m_phase != 0 && m_phase != 8 && cyc < 100);
        if (cyc >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL instr_bound: op %0d did not complete, %0d cycles used, limit 100", op, cyc);
        end
    endtask

    initial begin : monitor
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL vec%0d: phase %0d strobes %b, required phase %0d strobes %b",
                             n_vec, act[12:9], act[8:0], e[12:9], e[8:0]);
                end
            end
        end
    end

    initial begin : driver
        @(posedge clk);
        #1;
        do_reset();
        run_instr(3'd2, 2);
        run_instr(3'd6, 2);
        run_instr(3'd1, 1);
        run_instr(3'd1, 0);
        run_instr(3'd7, 2);
        run_instr(3'd5, 2);
`ifdef RISC_CTRL_MEM_WAIT_EN
        stall_at = 5;
        stall_left = 3;
        run_instr(3'd5, 2);
        stall_left = 0;
`endif
        run_instr(3'd0, 2);
        repeat (20) step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a HALTED cycle.
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (phase !== 4'd0 || halt !== 1'b0 || sel !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst: phase %0d halt %b sel %b, required phase 0 halt 0 sel 1",
                     phase, halt, sel);
        end
        @(posedge clk);
        #1;
        do_reset();

`ifdef RISC_CTRL_MEM_WAIT_EN
        rand_rdy = 1'b1;
`endif
        repeat (40) run_instr(3'($urandom_range(1, 7)), 2);
        run_instr(3'd0, 2);
        repeat (3) step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
